uart_tx_fifo: RTL and testbench

Byte FIFO and handoff controller that sits directly upstream of the UART transmitter. It accepts bytes from a producer with a write strobe and buffers them. It presents one byte at a time to the transmitter with a one-cycle start pulse, then waits for the transmitter's busy signal to rise and fall before it launches the next byte. This replaces the hard-wired start/fixed-data hookup at the transmitter input.

---
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through a start/busy handoff FSM
// Ports: clk, rst (sync, active-high); wr_en/wr_data producer side; clear_ovf clears sticky overflow;
// tx_busy from transmitter; tx_data/tx_start to transmitter; full/almost_full/empty/count status; overflow sticky drop flag.
// Optional UART_TX_FIFO_STATS_EN adds sent_cnt (completed frames) and drop_cnt (dropped writes + ack timeouts), both saturating.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int AFULL_LVL = 12,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_ovf,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [15:0]       sent_cnt,
  output logic [7:0]        drop_cnt
`endif
);
  localparam int CW = ADDR_W + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tmo;
  logic push, drop, pop, tmo_hit;
  logic [CW-1:0] count_nxt;
  always_comb begin
    push = wr_en && !full;
    drop = wr_en && full;
    pop = (state == IDLE) && !empty && !tx_busy;
    tmo_hit = (state == WAIT_ACK) && !tx_busy && (tmo == TMO_LAST);
    count_nxt = count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk)
    if (!rst && push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tmo <= '0;
      tx_data <= '0;
      tx_start <= 1'b0;
      count <= '0;
      full <= 1'b0;
      almost_full <= 1'b0;
      empty <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count_nxt;
      full <= count_nxt == DEPTH_C;
      almost_full <= count_nxt >= AFULL_C;
      empty <= count_nxt == '0;
      overflow <= drop | (overflow & ~clear_ovf);
      tx_start <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          tx_data <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
          tx_start <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          tmo <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (tx_busy) state <= WAIT_DONE;
        else begin
          tmo <= tmo + 1'b1;
          if (tmo_hit) state <= IDLE;
        end
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef UART_TX_FIFO_STATS_EN
  logic [8:0] drop_sum;
  always_comb drop_sum = {1'b0, drop_cnt} + 9'(drop) + 9'(tmo_hit);
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == WAIT_DONE && !tx_busy && sent_cnt != 16'hFFFF) sent_cnt <= sent_cnt + 1'b1;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench for uart_tx_fifo against a queue-based model
module tb_uart_tx_fifo;
  localparam int DEPTH = 16, AFULL = 12, TMO = 64;
  logic clk = 0, rst = 0, wr_en = 0, clear_ovf = 0, tx_busy = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] tx_data;
  logic tx_start, full, almost_full, empty, overflow;
  logic [4:0] count;
`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0] sent_cnt;
  logic [7:0] drop_cnt;
`endif
  uart_tx_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clear_ovf(clear_ovf),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .full(full),
    .almost_full(almost_full), .empty(empty), .count(count), .overflow(overflow)
`ifdef UART_TX_FIFO_STATS_EN
    , .sent_cnt(sent_cnt), .drop_cnt(drop_cnt)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  byte unsigned q[$];
  bit m_ovf = 0, prev_start = 0;
  int starts = 0, cyc = 0, last_start = 0;
  int tx_mode = 0, busy_len = 1, busy_left = 0;
  task automatic cycle(input bit wr, input logic [7:0] d, input bit clr);
    int pre;
    bit b_pre;
    byte unsigned e;
    wr_en = wr; wr_data = d; clear_ovf = clr;
    pre = q.size(); b_pre = tx_busy;
    @(posedge clk); #1;
    wr_en = 0; clear_ovf = 0; cyc++;
    if (rst) begin
      q.delete(); m_ovf = 0;
      checks++;
      if (tx_start !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx start=%b data=%h want 0/00", tx_start, tx_data); end
    end else begin
      if (clr) m_ovf = 0;
      if (wr) begin
        if (pre < DEPTH) q.push_back(d); else m_ovf = 1;
      end
      if (tx_start === 1'b1) begin
        starts++; last_start = cyc;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL pulse_on_empty data=%h want no pulse", tx_data); end
        else begin
          e = q.pop_front();
          checks++;
          if (tx_data !== e) begin errors++; $display("FAIL tx_data got=%h want=%h", tx_data, e); end
        end
        checks++;
        if (b_pre || prev_start) begin errors++; $display("FAIL pulse_gating busy_before=%b prev_start=%b want 0/0", b_pre, prev_start); end
      end
    end
    prev_start = (tx_start === 1'b1);
    if (tx_mode == 1) begin
      if (busy_left > 0) begin busy_left--; if (busy_left == 0) tx_busy = 0; end
      if (tx_start === 1'b1) begin tx_busy = 1; busy_left = busy_len; end
    end
    checks += 5;
    if (count !== 5'(q.size())) begin errors++; $display("FAIL count got=%0d want=%0d", count, q.size()); end
    if (empty !== (q.size() == 0)) begin errors++; $display("FAIL empty got=%b want=%b", empty, q.size() == 0); end
    if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL full got=%b want=%b", full, q.size() == DEPTH); end
    if (almost_full !== (q.size() >= AFULL)) begin errors++; $display("FAIL almost_full got=%b want=%b", almost_full, q.size() >= AFULL); end
    if (overflow !== m_ovf) begin errors++; $display("FAIL overflow got=%b want=%b", overflow, m_ovf); end
  endtask
  task automatic run_until_quiet(input int budget);
    while (budget > 0 && (q.size() != 0 || tx_busy)) begin cycle(0, 0, 0); budget--; end
    repeat (4) cycle(0, 0, 0);
    checks++;
    if (q.size() != 0 || tx_busy) begin errors++; $display("FAIL drain_timeout left=%0d busy=%b want 0/0", q.size(), tx_busy); end
  endtask
  task automatic test_reset;
    rst = 1; cycle(0, 0, 0); cycle(0, 0, 0); rst = 0;
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL reset_state empty=%b count=%0d want 1/0", empty, count); end
    repeat (20) cycle(0, 0, 0);
    checks++;
    if (starts != 0) begin errors++; $display("FAIL idle_no_start starts=%0d want 0", starts); end
  endtask
  task automatic test_single;
    int s0 = starts;
    tx_mode = 1; busy_len = 160;
    cycle(1, 8'h55, 0);
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL latency_early tx_start=%b want 0", tx_start); end
    cycle(0, 0, 0);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h55) begin errors++; $display("FAIL latency start=%b data=%h want 1/55", tx_start, tx_data); end
    repeat (200) cycle(0, 0, 0);
    checks++;
    if (starts != s0 + 1) begin errors++; $display("FAIL single_pulse starts=%0d want %0d", starts - s0, 1); end
  endtask
  task automatic test_back_to_back;
    int s0 = starts;
    tx_mode = 1; busy_len = 160;
    cycle(1, 8'h12, 0); cycle(1, 8'h34, 0); cycle(1, 8'h56, 0);
    run_until_quiet(1000);
    checks++;
    if (starts != s0 + 3) begin errors++; $display("FAIL b2b_pulses got=%0d want=3", starts - s0); end
  endtask
  task automatic test_fill;
    tx_mode = 0; tx_busy = 1;
    cycle(0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      cycle(1, 8'(i), 0);
      if (i == 10) begin checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL afull_11 got=%b want=0", almost_full); end end
      if (i == 11) begin checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL afull_12 got=%b want=1", almost_full); end end
      if (i == 15) begin checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_16 got=%b want=1", full); end end
      if (i == 16) begin checks++; if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL drop_17 ovf=%b count=%0d want 1/16", overflow, count); end end
    end
    cycle(0, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clear_ovf got=%b want=0", overflow); end
    cycle(1, 8'hEE, 1);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL set_wins got=%b want=1", overflow); end
    cycle(0, 0, 1);
    tx_busy = 0; busy_left = 0; tx_mode = 1; busy_len = 2;
    run_until_quiet(2000);
  endtask
  task automatic test_timeout;
    int s0 = starts, t1 = -1, t2 = -1, budget = 400;
    tx_mode = 2; tx_busy = 0;
    cycle(1, 8'hA5, 0); cycle(1, 8'hB6, 0);
    while (budget > 0 && t2 < 0) begin
      if (starts == s0 + 1 && t1 < 0) t1 = last_start;
      if (starts == s0 + 2) t2 = last_start;
      if (t2 < 0) cycle(0, 0, 0);
      budget--;
    end
    checks++;
    if (t1 < 0 || t2 - t1 != TMO + 2) begin errors++; $display("FAIL ack_timeout gap=%0d want=%0d", t2 - t1, TMO + 2); end
    repeat (TMO + 5) cycle(0, 0, 0);
    checks++;
    if (starts != s0 + 2) begin errors++; $display("FAIL timeout_pulses got=%0d want=2", starts - s0); end
  endtask
  task automatic test_reset_mid;
    int s0;
    tx_mode = 1; busy_len = 40;
    for (int i = 0; i < 6; i++) cycle(1, 8'(8'h30 + i), 0);
    cycle(0, 0, 0);
    checks++;
    if (count !== 5'd5 || tx_busy !== 1'b1) begin errors++; $display("FAIL pre_reset count=%0d busy=%b want 5/1", count, tx_busy); end
    rst = 1; cycle(0, 0, 0); rst = 0;
    tx_mode = 0; tx_busy = 0; busy_left = 0;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || tx_start !== 1'b0) begin errors++; $display("FAIL mid_reset count=%0d empty=%b start=%b want 0/1/0", count, empty, tx_start); end
    s0 = starts;
    repeat (5) cycle(0, 0, 0);
    checks++;
    if (starts != s0) begin errors++; $display("FAIL post_reset_start got=%0d want=0", starts - s0); end
    tx_mode = 1; busy_len = 3;
    cycle(1, 8'h77, 0); cycle(0, 0, 0);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h77) begin errors++; $display("FAIL post_reset_idle start=%b data=%h want 1/77", tx_start, tx_data); end
    run_until_quiet(200);
  endtask
  task automatic test_random;
    tx_mode = 1;
    repeat (800) begin
      busy_len = $urandom_range(1, 12);
      cycle($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
    end
    run_until_quiet(4000);
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_fill;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
